// File: rtl/mips32_fetch_unit.sv
// mips32_fetch_unit: instruction fetch stage feeding the mips32 core.
// Holds the fetch PC, keeps at most one instruction-memory read in flight,
// and buffers returned words with their PCs in a small FIFO. A redirect
// from the core flushes the buffer and discards any in-flight response.
// Optional build macro MIPS32_FETCH_PERF_EN adds fetch_count/flush_count
// event counter outputs.
module mips32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef MIPS32_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   hold_instr;
    logic [31:0]   hold_pc;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    // Request, handshake and head-of-buffer decode from registered state
    always_comb begin
        imem_req       = !reset && (state == IDLE) && (count < DEPTH_C) && !redirect_valid;
        imem_addr      = fetch_pc;
        instr_valid    = (count != '0);
        push           = (state == WAIT) && imem_ack && !redirect_valid;
        pop            = instr_valid && instr_ready;
        instr          = instr_valid ? fifo_instr[rd_ptr] : hold_instr;
        instr_pc       = instr_valid ? fifo_pc[rd_ptr]    : hold_pc;
        unused_pc_bits = ^redirect_pc[1:0];
    end

    // Fetch FSM, fetch PC, buffer pointers/occupancy and the empty-output hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            hold_instr <= instr;
            hold_pc    <= instr_pc;
            if (redirect_valid) begin
                count    <= '0;
                wr_ptr   <= rd_ptr;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                // An ack landing in the redirect cycle retires the outstanding
                // read, so DROP only persists while that read is still pending.
                case (state)
                    WAIT:    state <= imem_ack ? IDLE : DROP;
                    DROP:    state <= imem_ack ? IDLE : DROP;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (imem_req) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_ack) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= IDLE;
                        end
                    end
                    DROP: begin
                        if (imem_ack) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage: each accepted response is written with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef MIPS32_FETCH_PERF_EN
    // Event counters: buffer pushes and cycles with a redirect asserted
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// tb_mips32_fetch_unit: directed bench for mips32_fetch_unit. Two instances:
// dut (RESET_PC=0, driven by the bench) and dut2 (RESET_PC=FFFF_FFF8, free
// running). Memory models return word = addr + K after a set latency.
`timescale 1ns/1ps
module tb_mips32_fetch_unit;

    localparam logic [31:0] K = 32'h0211_9020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

`ifdef MIPS32_FETCH_PERF_EN
    logic [31:0] fetch_count, flush_count, fetch_count2, flush_count2;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int m1_cnt = 0;
    int m2_cnt = 0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m2_addr = '0;

    logic [31:0] req_q[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_data[$];
    int          dlv_cyc[$];
    logic [31:0] d2_pc[$];
    logic [31:0] d2_data[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    mips32_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef MIPS32_FETCH_PERF_EN
        ,.fetch_count   (fetch_count)
        ,.flush_count   (flush_count)
`endif
    );

    mips32_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ack       (ack2),
        .imem_rdata     (rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (valid2),
        .instr_ready    (1'b1),
        .instr          (instr2),
        .instr_pc       (pc2)
`ifdef MIPS32_FETCH_PERF_EN
        ,.fetch_count   (fetch_count2)
        ,.flush_count   (flush_count2)
`endif
    );

    // Memory model for dut: ack mem_lat cycles after the request cycle
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (reset) begin
            m1_cnt = 0;
        end else begin
            if (m1_cnt != 0) begin
                m1_cnt--;
                if (m1_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = m1_addr + K;
                end
            end
            if (imem_req) begin
                m1_addr = imem_addr;
                m1_cnt  = mem_lat;
            end
        end
    end

    // Memory model for dut2: fixed one-cycle latency
    always @(negedge clk) begin
        ack2 = 1'b0;
        if (reset) begin
            m2_cnt = 0;
        end else begin
            if (m2_cnt != 0) begin
                m2_cnt--;
                if (m2_cnt == 0) begin
                    ack2   = 1'b1;
                    rdata2 = m2_addr + K;
                end
            end
            if (req2) begin
                m2_addr = addr2;
                m2_cnt  = 1;
            end
        end
    end

    // Request and delivery logs
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req) req_q.push_back(imem_addr);
            if (instr_valid && instr_ready && !redirect_valid) begin
                dlv_pc.push_back(instr_pc);
                dlv_data.push_back(instr);
                dlv_cyc.push_back(cyc);
            end
            if (valid2) begin
                d2_pc.push_back(pc2);
                d2_data.push_back(instr2);
            end
        end
    end

    function automatic int cur_size(input int which);
        case (which)
            0:       return req_q.size();
            1:       return dlv_pc.size();
            default: return d2_pc.size();
        endcase
    endfunction

    task automatic wait_count(input int which, input int n, input int budget, input string name);
        int k = 0;
        while (cur_size(which) < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (cur_size(which) < n) begin
            errors++;
            $display("FAIL %s: timeout with %0d entries, required %0d", name, cur_size(which), n);
        end
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(posedge clk);
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = rdy;
        mem_lat        = lat;
        @(posedge clk);
        #1;
        req_q.delete();
        dlv_pc.delete();
        dlv_data.delete();
        dlv_cyc.delete();
        d2_pc.delete();
        d2_data.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required 00000000", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 00000000", instr_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 00000000", imem_addr); end
        checks++; if (addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr2: got %h required fffffff8", addr2); end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        do_reset(1, 1'b1);
        wait_count(1, 3, 40, "basic_wait");
        for (int unsigned i = 0; i < 3; i++) begin
            e = 32'(i * 4);
            checks++; if (req_q[i] !== e) begin errors++; $display("FAIL basic_req%0d: got %h required %h", i, req_q[i], e); end
            checks++; if (dlv_pc[i] !== e) begin errors++; $display("FAIL basic_pc%0d: got %h required %h", i, dlv_pc[i], e); end
            checks++; if (dlv_data[i] !== e + K) begin errors++; $display("FAIL basic_data%0d: got %h required %h", i, dlv_data[i], e + K); end
        end
        for (int unsigned i = 1; i < 3; i++) begin
            checks++;
            if (dlv_cyc[i] - dlv_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL basic_rate%0d: got %0d cycles required 2", i, dlv_cyc[i] - dlv_cyc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        do_reset(1, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (req_q.size() != 4) begin errors++; $display("FAIL bp_reqs: got %0d required 4", req_q.size()); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b required 0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h required 00000000", instr_pc); end
        checks++; if (instr !== K) begin errors++; $display("FAIL bp_head_instr: got %h required %h", instr, K); end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_count(1, 4, 40, "bp_dlv_wait");
        wait_count(0, 5, 40, "bp_req_wait");
        for (int unsigned i = 0; i < 4; i++) begin
            e = 32'(i * 4);
            checks++; if (dlv_pc[i] !== e) begin errors++; $display("FAIL bp_pc%0d: got %h required %h", i, dlv_pc[i], e); end
        end
        checks++; if (req_q[4] !== 32'h10) begin errors++; $display("FAIL bp_resume: got %h required 00000010", req_q[4]); end
    endtask

    task automatic test_redirect_drop();
        do_reset(3, 1'b1);
        wait_count(0, 3, 60, "drop_wait_req8");
        checks++; if (req_q[2] !== 32'h8) begin errors++; $display("FAIL drop_req8: got %h required 00000008", req_q[2]); end
        checks++; if (dlv_pc.size() != 2) begin errors++; $display("FAIL drop_pre_dlv: got %0d required 2", dlv_pc.size()); end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_count(0, 4, 40, "drop_wait_req");
        wait_count(1, 3, 60, "drop_wait_dlv");
        checks++; if (req_q[3] !== 32'h40) begin errors++; $display("FAIL drop_next_addr: got %h required 00000040", req_q[3]); end
        checks++; if (dlv_pc[2] !== 32'h40) begin errors++; $display("FAIL drop_first_pc: got %h required 00000040", dlv_pc[2]); end
        checks++; if (dlv_data[2] !== 32'h40 + K) begin errors++; $display("FAIL drop_first_data: got %h required %h", dlv_data[2], 32'h40 + K); end
    endtask

    task automatic test_redirect_ack();
        do_reset(1, 1'b0);
        wait_count(0, 3, 40, "rack_wait_req8");
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rack_pre_valid: got %b required 1", instr_valid); end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rack_no_req: got %b required 0", imem_req); end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rack_flushed: got %b required 0", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rack_hold_pc: got %h required 00000000", instr_pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rack_idle_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rack_addr: got %h required 00000100", imem_addr); end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_count(1, 1, 40, "rack_wait_dlv");
        checks++; if (dlv_pc[0] !== 32'h100) begin errors++; $display("FAIL rack_first_pc: got %h required 00000100", dlv_pc[0]); end
        checks++; if (dlv_data[0] !== 32'h100 + K) begin errors++; $display("FAIL rack_first_data: got %h required %h", dlv_data[0], 32'h100 + K); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset(1, 1'b1);
        wait_count(2, 3, 40, "wrap_wait");
        for (int unsigned i = 0; i < 3; i++) begin
            checks++; if (d2_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc%0d: got %h required %h", i, d2_pc[i], exp_pc[i]); end
            checks++; if (d2_data[i] !== exp_pc[i] + K) begin errors++; $display("FAIL wrap_data%0d: got %h required %h", i, d2_data[i], exp_pc[i] + K); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1, 1'b0);
        wait_count(0, 4, 40, "rmid_wait_req12");
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b required 1", instr_valid); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b required 0", imem_req); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h required 00000000", instr_pc); end
        req_q.delete();
        dlv_pc.delete();
        dlv_data.delete();
        dlv_cyc.delete();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_after: got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr_after: got %h required 00000000", imem_addr); end
        wait_count(1, 1, 40, "rmid_wait_dlv");
        checks++; if (dlv_pc[0] !== 32'h0) begin errors++; $display("FAIL rmid_first_pc: got %h required 00000000", dlv_pc[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
